// File: rtl/stickit_pkg.sv
// Shared definitions for charlieplexed StickIt! LED Digits scanning:
// scan state encoding, hex font (bits [6:0] = segments g..a) and the
// helper that splices a digit's anode line into its segment mask.
package stickit_pkg;

  typedef enum logic [1:0] {
    ST_LATCH = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } state_t;

  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Segment i sits on line i below the anode and on line i+1 above it,
  // so the anode bit is inserted at position k and the upper segments
  // shift up by one line.
  function automatic logic [7:0] insert_anode(input logic [6:0] mask,
                                              input logic [2:0] k);
    logic [7:0] m8;
    logic [7:0] low;
    m8  = {1'b0, mask};
    low = (8'd1 << k) - 8'd1;
    return (m8 & low) | ((m8 & ~low) << 1) | (8'd1 << k);
  endfunction

endpackage

// File: rtl/stickit_charlie_map.sv
// Combinational charlieplex line mapper: turns a digit index, hex nibble
// and enable into the 8-line output value / output enable pair. Anode is
// driven high, lit segments are driven low, unlit segments float.
module stickit_charlie_map
  import stickit_pkg::*;
(
  input  logic [2:0] digit,
  input  logic [3:0] nibble,
  input  logic       en,
  output logic [7:0] o,
  output logic [7:0] oe
);

  // All lines float unless the digit is enabled for display.
  always_comb begin
    o  = '0;
    oe = '0;
    if (en) begin
      oe = insert_anode(FONT[nibble], digit);
      o  = 8'd1 << digit;
    end
  end

endmodule

// File: rtl/stickit_scan.sv
// Charlieplexed hex-digit scanner for StickIt! LED Digits (1..8 digits).
// Each frame: one LATCH cycle capturing VALUE/DIGIT_EN into shadow
// registers, then per digit a BLANK slot (all lines off) followed by an
// ON slot. Slot timing is counted in scan ticks of CLK_DIV cycles.
// Optional macro STICKIT_LZB_EN enables leading-zero blanking at LATCH.
module stickit_scan
  import stickit_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int CLK_DIV     = 200,
  parameter int ON_TICKS    = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [4*NUM_DIGITS-1:0] VALUE,
  input  logic [NUM_DIGITS-1:0]   DIGIT_EN,
  output logic [7:0]              S_O,
  output logic [7:0]              S_OE,
  output logic                    FRAME_DONE,
  output logic [2:0]              CUR_DIGIT
);

  localparam int PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MAXT = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
  localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
  localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
  localparam logic [2:0]    DIGIT_LAST = 3'(NUM_DIGITS - 1);

  state_t                  state;
  state_t                  state_next;
  logic [PW-1:0]           presc;
  logic [TW-1:0]           tcnt;
  logic [2:0]              digit;
  logic [2:0]              digit_next;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_en;
  logic [NUM_DIGITS-1:0]   eff_en;
  logic                    tick;
  logic                    last_digit;
  logic                    fd_p0;
  logic                    map_en;
  logic [31:0]             val_pad;
  logic [7:0]              en_pad;
  logic [3:0]              nibble;
  logic [7:0]              o_p0;
  logic [7:0]              oe_p0;

  assign tick       = (presc == PRESC_LAST);
  assign last_digit = (digit == DIGIT_LAST);

  // Pad shadows to the full 8-digit width so the 3-bit digit index never
  // selects outside the vectors when fewer digits are fitted.
  assign val_pad = 32'(shadow_val);
  assign en_pad  = 8'(shadow_en);
  assign nibble  = val_pad[{digit, 2'b00} +: 4];
  assign map_en  = (state == ST_ON) && en_pad[digit];

  // Enable that will be captured at LATCH.
  always_comb begin
    eff_en = '0;
`ifdef STICKIT_LZB_EN
    begin
      logic any_above;
      any_above = 1'b0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
        any_above = any_above | (|VALUE[4*k +: 4]);
        eff_en[k] = DIGIT_EN[k] & (any_above | (k == 0));
      end
    end
`else
    eff_en = DIGIT_EN;
`endif
  end

  // Next-state, next-digit and frame-end pulse.
  always_comb begin
    state_next = state;
    digit_next = digit;
    fd_p0      = 1'b0;
    case (state)
      ST_LATCH: begin
        state_next = ST_BLANK;
        digit_next = '0;
      end
      ST_BLANK: begin
        if (tick && (tcnt == BLANK_LAST)) state_next = ST_ON;
      end
      ST_ON: begin
        if (tick && (tcnt == ON_LAST)) begin
          if (last_digit) begin
            state_next = ST_LATCH;
            digit_next = '0;
            fd_p0      = 1'b1;
          end else begin
            state_next = ST_BLANK;
            digit_next = digit + 3'd1;
          end
        end
      end
      default: begin
        state_next = ST_LATCH;
        digit_next = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_LATCH;
    else       state <= state_next;
  end

  // Prescaler, per-state tick counter and digit index.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc <= '0;
      tcnt  <= '0;
      digit <= '0;
    end else begin
      presc <= ((state == ST_LATCH) || tick) ? '0 : presc + PW'(1);
      if (state_next != state) tcnt <= '0;
      else if (tick)           tcnt <= tcnt + TW'(1);
      digit <= digit_next;
    end
  end

  // Frame shadow: display content only changes at LATCH.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      shadow_val <= '0;
      shadow_en  <= '0;
    end else if (state == ST_LATCH) begin
      shadow_val <= VALUE;
      shadow_en  <= eff_en;
    end
  end

  stickit_charlie_map u_map (
    .digit  (digit),
    .nibble (nibble),
    .en     (map_en),
    .o      (o_p0),
    .oe     (oe_p0)
  );

  // Registered pad drive and status, one cycle behind the state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      S_O        <= '0;
      S_OE       <= '0;
      FRAME_DONE <= 1'b0;
      CUR_DIGIT  <= '0;
    end else begin
      S_O        <= o_p0;
      S_OE       <= oe_p0;
      FRAME_DONE <= fd_p0;
      CUR_DIGIT  <= digit;
    end
  end

endmodule
